// File: rtl/fabric_reset_sequencer.sv
// fabric_reset_sequencer
// Holds every fabric clock domain in reset until INIT_DONE, DDR_READY and
// FPLL_LOCK are all high. It then releases the domains one at a time, bit 0
// first, with a fixed number of cycles between releases. If any readiness
// input drops, or a software restart is requested, all domains go back into
// reset and the sequence starts over. A sticky flag records that readiness
// did not arrive within the allowed window.
module fabric_reset_sequencer #(
    parameter int NUM_DOMAINS   = 4,
    parameter int STAGE_GAP     = 16,
    parameter int READY_TIMEOUT = 1000000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                   CLK_BASE,
    input  logic                   RESET,
    input  logic                   INIT_DONE,
    input  logic                   DDR_READY,
    input  logic                   FPLL_LOCK,
    input  logic                   SW_RESET_REQ,
    output logic [NUM_DOMAINS-1:0] DOMAIN_RESET_N,
    output logic                   SEQ_DONE,
    output logic                   TIMEOUT_ERR,
    output logic [2:0]             STATE
);

    // One counter serves both the readiness window and the release spacing,
    // so it is sized for the larger of the two.
    localparam int CNT_MAX = (STAGE_GAP > READY_TIMEOUT) ? STAGE_GAP : READY_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(READY_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [2:0] {
        HOLD       = 3'd0,
        WAIT_READY = 3'd1,
        GAP        = 3'd2,
        RUN        = 3'd3,
        FAULT      = 3'd4
    } state_t;

    state_t                 state_reg;
    logic [CNT_W-1:0]       counter_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [NUM_DOMAINS-1:0] rst_n_reg;
    logic                   seq_done_reg;
    logic                   timeout_reg;

    logic [2:0]             async_in;
    logic [2:0]             sync_out;
    logic                   ready_all;
    logic [NUM_DOMAINS-1:0] release_mask;

    assign async_in = {FPLL_LOCK, DDR_READY, INIT_DONE};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;

            // Multi-flop synchroniser for one asynchronous readiness input.
            always_ff @(posedge CLK_BASE) begin
                if (RESET) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], async_in[gi]};
                end
            end

            assign sync_out[gi] = chain_reg[SYNC_STAGES-1];
        end

        // One-hot mask selecting the domain that the current stage releases.
        for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_mask
            assign release_mask[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign ready_all = &sync_out;

    // Sequencer FSM. Restart requests outrank ready loss, and ready loss
    // outranks normal progress. Every output is a register.
    always_ff @(posedge CLK_BASE) begin
        if (RESET) begin
            state_reg    <= HOLD;
            counter_reg  <= '0;
            idx_reg      <= '0;
            rst_n_reg    <= '0;
            seq_done_reg <= 1'b0;
            timeout_reg  <= 1'b0;
        end else if (SW_RESET_REQ) begin
            // The timeout flag survives a software restart.
            state_reg    <= HOLD;
            counter_reg  <= '0;
            idx_reg      <= '0;
            rst_n_reg    <= '0;
            seq_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                HOLD: begin
                    counter_reg  <= '0;
                    idx_reg      <= '0;
                    rst_n_reg    <= '0;
                    seq_done_reg <= 1'b0;
                    state_reg    <= WAIT_READY;
                end
                WAIT_READY: begin
                    // If readiness arrives on the last window cycle, it wins.
                    if (ready_all) begin
                        state_reg   <= GAP;
                        counter_reg <= '0;
                        idx_reg     <= '0;
                    end else if (counter_reg == TIMEOUT_LAST) begin
                        state_reg   <= FAULT;
                        timeout_reg <= 1'b1;
                    end else begin
                        counter_reg <= counter_reg + 1'b1;
                    end
                end
                GAP: begin
                    if (!ready_all) begin
                        state_reg    <= HOLD;
                        rst_n_reg    <= '0;
                        seq_done_reg <= 1'b0;
                    end else if (counter_reg == GAP_LAST) begin
                        rst_n_reg <= rst_n_reg | release_mask;
                        if (idx_reg == IDX_LAST) begin
                            state_reg    <= RUN;
                            seq_done_reg <= 1'b1;
                        end else begin
                            idx_reg     <= idx_reg + 1'b1;
                            counter_reg <= '0;
                        end
                    end else begin
                        counter_reg <= counter_reg + 1'b1;
                    end
                end
                RUN: begin
                    if (!ready_all) begin
                        state_reg    <= HOLD;
                        rst_n_reg    <= '0;
                        seq_done_reg <= 1'b0;
                    end
                end
                FAULT: begin
                    // Late recovery: start releasing even after a timeout.
                    if (ready_all) begin
                        state_reg   <= GAP;
                        counter_reg <= '0;
                        idx_reg     <= '0;
                    end
                end
                default: begin
                    state_reg    <= HOLD;
                    rst_n_reg    <= '0;
                    seq_done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign DOMAIN_RESET_N = rst_n_reg;
    assign SEQ_DONE       = seq_done_reg;
    assign TIMEOUT_ERR    = timeout_reg;
    assign STATE          = state_reg;

endmodule

// File: tb/tb_fabric_reset_sequencer.sv
// Bench for fabric_reset_sequencer. A reference model follows the sequencer
// from edge timestamps: it records when each phase began and derives how
// many domains should be out of reset from the elapsed edge count. A compare
// process checks every output against the model on every cycle. Directed
// scenarios pin both the DUT and the model to hand-computed values at
// specific edges.
module tb_fabric_reset_sequencer;

    localparam int N_DOM = 4;
    localparam int GAP_C = 16;
    localparam int TMO_C = 100;
    localparam int SYNC  = 2;

    localparam int M_HOLD  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_SEQ   = 2;
    localparam int M_FAULT = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             init_done = 1'b0;
    logic             ddr_ready = 1'b0;
    logic             fpll_lock = 1'b0;
    logic             sw_req = 1'b0;
    logic [N_DOM-1:0] dom_rst_n;
    logic             seq_done;
    logic             tmo_err;
    logic [2:0]       state;

    fabric_reset_sequencer #(
        .NUM_DOMAINS  (N_DOM),
        .STAGE_GAP    (GAP_C),
        .READY_TIMEOUT(TMO_C),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .CLK_BASE      (clk),
        .RESET         (rst),
        .INIT_DONE     (init_done),
        .DDR_READY     (ddr_ready),
        .FPLL_LOCK     (fpll_lock),
        .SW_RESET_REQ  (sw_req),
        .DOMAIN_RESET_N(dom_rst_n),
        .SEQ_DONE      (seq_done),
        .TIMEOUT_ERR   (tmo_err),
        .STATE         (state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         n = 0;
    int         mode = M_HOLD;
    int         t0 = 0;
    bit         m_tmo = 1'b0;
    bit         raw_q[$];
    bit         started = 1'b0;
    logic [3:0] exp_rst = '0;
    logic       exp_done = 1'b0;
    logic [2:0] exp_state = '0;
    logic       exp_tmo = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    // ready_all seen at an edge is the AND of the raw inputs sampled SYNC edges earlier.
    task model_step();
        bit ready_now;
        bit raw;
        int k;
        raw = init_done & ddr_ready & fpll_lock;
        n++;
        if (rst) begin
            mode  = M_HOLD;
            m_tmo = 1'b0;
            raw_q.delete();
            for (int i = 0; i < SYNC; i++) raw_q.push_back(1'b0);
        end else begin
            ready_now = raw_q[0];
            void'(raw_q.pop_front());
            raw_q.push_back(raw);
            if (sw_req) begin
                mode = M_HOLD;
            end else begin
                case (mode)
                    M_HOLD: begin
                        mode = M_WAIT;
                        t0   = n;
                    end
                    M_WAIT: begin
                        if (ready_now) begin
                            mode = M_SEQ;
                            t0   = n;
                        end else if (n - t0 == TMO_C) begin
                            mode  = M_FAULT;
                            m_tmo = 1'b1;
                        end
                    end
                    M_SEQ: begin
                        if (!ready_now) mode = M_HOLD;
                    end
                    default: begin
                        if (ready_now) begin
                            mode = M_SEQ;
                            t0   = n;
                        end
                    end
                endcase
            end
        end
        exp_rst  = '0;
        exp_done = 1'b0;
        exp_tmo  = m_tmo;
        case (mode)
            M_HOLD:  exp_state = 3'd0;
            M_WAIT:  exp_state = 3'd1;
            M_FAULT: exp_state = 3'd4;
            default: begin
                k = (n - t0) / GAP_C;
                if (k > N_DOM) k = N_DOM;
                exp_rst   = 4'((1 << k) - 1);
                exp_done  = (k == N_DOM);
                exp_state = (k == N_DOM) ? 3'd3 : 3'd2;
            end
        endcase
        started = 1'b1;
    endtask

    always @(posedge clk) model_step();

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("cyc DOMAIN_RESET_N", 32'(dom_rst_n), 32'(exp_rst));
            chk("cyc SEQ_DONE", 32'(seq_done), 32'(exp_done));
            chk("cyc STATE", 32'(state), 32'(exp_state));
            chk("cyc TIMEOUT_ERR", 32'(tmo_err), 32'(exp_tmo));
        end
    end

    task automatic step(input int m);
        repeat (m) @(negedge clk);
    endtask

    // Pin DUT and model to a hand-computed expectation.
    task automatic pin(input string nm, input logic [3:0] r, input logic d,
                       input logic [2:0] s, input logic t);
        $display("pin %s: rst_n=%b done=%b state=%0d tmo=%b", nm, dom_rst_n, seq_done, state, tmo_err);
        chk({nm, " rst_n"}, 32'(dom_rst_n), 32'(r));
        chk({nm, " done"}, 32'(seq_done), 32'(d));
        chk({nm, " state"}, 32'(state), 32'(s));
        chk({nm, " tmo"}, 32'(tmo_err), 32'(t));
        chk({nm, " model rst_n"}, 32'(exp_rst), 32'(r));
        chk({nm, " model done"}, 32'(exp_done), 32'(d));
        chk({nm, " model state"}, 32'(exp_state), 32'(s));
        chk({nm, " model tmo"}, 32'(exp_tmo), 32'(t));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        init_done = 1'b0;
        ddr_ready = 1'b0;
        fpll_lock = 1'b0;
        sw_req    = 1'b0;
        step(3);
        pin("reset", 4'b0000, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // Normal bring-up: E1 is three edges after WAIT_READY entry.
        do_reset();
        step(3);
        {init_done, ddr_ready, fpll_lock} = 3'b111;
        step(2);  pin("up E1+1", 4'b0000, 1'b0, 3'd1, 1'b0);
        step(1);  pin("up E1+2", 4'b0000, 1'b0, 3'd2, 1'b0);
        step(15); pin("up E1+17", 4'b0000, 1'b0, 3'd2, 1'b0);
        step(1);  pin("up E1+18", 4'b0001, 1'b0, 3'd2, 1'b0);
        step(16); pin("up E1+34", 4'b0011, 1'b0, 3'd2, 1'b0);
        step(16); pin("up E1+50", 4'b0111, 1'b0, 3'd2, 1'b0);
        step(16); pin("up E1+66", 4'b1111, 1'b1, 3'd3, 1'b0);

        // Software restart from RUN.
        sw_req = 1'b1;
        step(1);  pin("sw S", 4'b0000, 1'b0, 3'd0, 1'b0);
        sw_req = 1'b0;
        step(1);  pin("sw S+1", 4'b0000, 1'b0, 3'd1, 1'b0);
        step(1);  pin("sw S+2", 4'b0000, 1'b0, 3'd2, 1'b0);
        step(64); pin("sw S+66", 4'b1111, 1'b1, 3'd3, 1'b0);

        // Ready loss mid-sequence, then restart from bit 0.
        do_reset();
        {init_done, ddr_ready, fpll_lock} = 3'b111;
        step(35); pin("loss E1+34", 4'b0011, 1'b0, 3'd2, 1'b0);
        fpll_lock = 1'b0;
        step(2);  pin("loss +1", 4'b0011, 1'b0, 3'd2, 1'b0);
        step(1);  pin("loss +2", 4'b0000, 1'b0, 3'd0, 1'b0);
        step(1);  pin("loss +3", 4'b0000, 1'b0, 3'd1, 1'b0);
        fpll_lock = 1'b1;
        step(18); pin("relock E2+17", 4'b0000, 1'b0, 3'd2, 1'b0);
        step(1);  pin("relock E2+18", 4'b0001, 1'b0, 3'd2, 1'b0);

        // Timeout, then late recovery with the flag kept.
        do_reset();
        init_done = 1'b1;
        fpll_lock = 1'b1;
        step(100); pin("tmo W+99", 4'b0000, 1'b0, 3'd1, 1'b0);
        step(1);   pin("tmo W+100", 4'b0000, 1'b0, 3'd4, 1'b1);
        ddr_ready = 1'b1;
        step(18);  pin("recov E1+17", 4'b0000, 1'b0, 3'd2, 1'b1);
        step(1);   pin("recov E1+18", 4'b0001, 1'b0, 3'd2, 1'b1);
        step(48);  pin("recov E1+66", 4'b1111, 1'b1, 3'd3, 1'b1);

        // RESET while in GAP at idx 2 clears everything, including the flag.
        sw_req = 1'b1;
        step(1);  pin("sw2 S", 4'b0000, 1'b0, 3'd0, 1'b1);
        sw_req = 1'b0;
        step(40); pin("gap idx2", 4'b0011, 1'b0, 3'd2, 1'b1);
        rst = 1'b1;
        step(1);  pin("mid reset", 4'b0000, 1'b0, 3'd0, 1'b0);
        step(1);

        // Readiness arrives exactly as the window expires: ready wins.
        rst       = 1'b0;
        init_done = 1'b1;
        fpll_lock = 1'b1;
        ddr_ready = 1'b0;
        step(1);
        step(97);
        ddr_ready = 1'b1;
        step(2);  pin("race W+99", 4'b0000, 1'b0, 3'd1, 1'b0);
        step(1);  pin("race W+100", 4'b0000, 1'b0, 3'd2, 1'b0);
        step(66); pin("race done", 4'b1111, 1'b1, 3'd3, 1'b0);

        // Software restart coinciding with ready loss.
        fpll_lock = 1'b0;
        step(2);  pin("both F+1", 4'b1111, 1'b1, 3'd3, 1'b0);
        sw_req = 1'b1;
        step(1);  pin("both F+2", 4'b0000, 1'b0, 3'd0, 1'b0);
        sw_req = 1'b0;
        step(1);  pin("both F+3", 4'b0000, 1'b0, 3'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
